// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator driven by a single pixel clock.
// Ports:
//   i_Clk           pixel clock
//   i_Rst_L         synchronous reset, active-low
//   i_Enable        pixel-clock enable; position advances only when high
//   o_HSync         horizontal sync (asserted level = SYNC_POLARITY)
//   o_VSync         vertical sync (asserted level = SYNC_POLARITY)
//   o_Active_Video  high while the current position is in the visible area
//   o_Col_Count     current column, 0..TOTAL_COLS-1
//   o_Row_Count     current row, 0..TOTAL_ROWS-1
//   o_Line_Start    one-cycle strobe on entering column 0
//   o_Frame_Start   one-cycle strobe on entering column 0 of row 0
// All outputs are registered together, so they always describe the same position.
module vga_sync_gen #(
   parameter int unsigned TOTAL_COLS    = 800,
   parameter int unsigned TOTAL_ROWS    = 525,
   parameter int unsigned ACTIVE_COLS   = 640,
   parameter int unsigned ACTIVE_ROWS   = 480,
   parameter int unsigned H_FRONT_PORCH = 16,
   parameter int unsigned H_SYNC_WIDTH  = 96,
   parameter int unsigned V_FRONT_PORCH = 10,
   parameter int unsigned V_SYNC_WIDTH  = 2,
   parameter bit          SYNC_POLARITY = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Enable,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic       o_Active_Video,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Line_Start,
   output logic       o_Frame_Start
);

   localparam int unsigned CW = 10;
   localparam int unsigned XW = 11;

   localparam int unsigned H_SYNC_START = ACTIVE_COLS + H_FRONT_PORCH;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_WIDTH;
   localparam int unsigned V_SYNC_START = ACTIVE_ROWS + V_FRONT_PORCH;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;

   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          active_q, active_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   // Widened copies of the next position so parameter sums cannot overflow.
   logic [XW-1:0] col_x;
   logic [XW-1:0] row_x;

   // Next position and the outputs that describe it.
   always_comb begin
      col_d         = col_q;
      row_d         = row_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (col_q == CW'(TOTAL_COLS - 1)) begin
         col_x = '0;
         row_x = (row_q == CW'(TOTAL_ROWS - 1)) ? '0 : XW'(row_q) + XW'(1);
      end else begin
         col_x = XW'(col_q) + XW'(1);
         row_x = XW'(row_q);
      end

      if (i_Enable) begin
         col_d         = CW'(col_x);
         row_d         = CW'(row_x);
         active_d      = (col_x < XW'(ACTIVE_COLS)) && (row_x < XW'(ACTIVE_ROWS));
         hsync_d       = ((col_x >= XW'(H_SYNC_START)) && (col_x < XW'(H_SYNC_END)))
                         ? SYNC_POLARITY : ~SYNC_POLARITY;
         vsync_d       = ((row_x >= XW'(V_SYNC_START)) && (row_x < XW'(V_SYNC_END)))
                         ? SYNC_POLARITY : ~SYNC_POLARITY;
         line_start_d  = (col_x == '0);
         frame_start_d = (col_x == '0) && (row_x == '0);
      end
   end

   // Reset parks the position on the last pixel so the first enabled edge lands on (0,0).
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         col_q         <= CW'(TOTAL_COLS - 1);
         row_q         <= CW'(TOTAL_ROWS - 1);
         hsync_q       <= ~SYNC_POLARITY;
         vsync_q       <= ~SYNC_POLARITY;
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign o_HSync        = hsync_q;
   assign o_VSync        = vsync_q;
   assign o_Active_Video = active_q;
   assign o_Col_Count    = col_q;
   assign o_Row_Count    = row_q;
   assign o_Line_Start   = line_start_q;
   assign o_Frame_Start  = frame_start_q;

endmodule
